// File: rtl/multicycle_main_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_main_fsm
//
// Main control FSM of the multicycle core. Each instruction is sequenced
// through FETCH / DECODE / EXECUTE / MEM / WB states. A memory ready handshake
// stalls FETCH, MEMRD and MEMWR. A wait counter trips a sticky FAULT after
// TIMEOUT consecutive not-ready cycles.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   op, func             instruction fields from the IR (stable until ir_write)
//   cond_ok              condition of current instruction passed (used in DECODE)
//   mem_ready            memory completed the request this cycle
//   mem_req, mem_w       memory request / write strobe
//   adr_src              0 = PC address, 1 = ALU result register address
//   ir_write, pc_write   IR / PC load enables
//   reg_w, branch        register file write / branch PC update
//   alu_src_a/b, alu_op  ALU operand selects, 1 = ALU decodes func, 0 = ADD
//   result_src           00 = ALU out reg, 01 = memory data, 10 = ALU direct
//   imm_src, reg_src     operand decode, combinational from op/func
//   instr_done           pulse on last cycle of a retired/nullified instruction
//   illegal              pulse in DECODE for op = 11
//   fault                sticky memory-timeout fault
//   state                current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_main_fsm #(
   parameter int OP_W    = 2,
   parameter int FUNC_W  = 6,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OP_W-1:0]   op,
   input  logic [FUNC_W-1:0] func,
   input  logic              cond_ok,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic              mem_w,
   output logic              adr_src,
   output logic              ir_write,
   output logic              pc_write,
   output logic              reg_w,
   output logic              branch,
   output logic [1:0]        alu_src_a,
   output logic [1:0]        alu_src_b,
   output logic              alu_op,
   output logic [1:0]        result_src,
   output logic [1:0]        imm_src,
   output logic [1:0]        reg_src,
   output logic              instr_done,
   output logic              illegal,
   output logic              fault,
   output logic [3:0]        state
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   localparam logic [OP_W-1:0] OP_DP  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_MEM = OP_W'(1);
   localparam logic [OP_W-1:0] OP_BR  = OP_W'(2);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_FAULT  = 4'd15
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             waiting;
   logic             timeout_hit;

   // Only func[5] (immediate) and func[0] (load) steer the sequence.
   logic unused_func;
   assign unused_func = ^func;

   // ---------------------------------------------------------------------------
   // Next state and wait counter
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (!cond_ok)            state_d = S_FETCH;
            else if (op == OP_MEM)   state_d = S_MEMADR;
            else if (op == OP_DP)    state_d = func[5] ? S_EXECI : S_EXECR;
            else if (op == OP_BR)    state_d = S_BRANCH;
            else                     state_d = S_FETCH;   // illegal op
         end
         S_MEMADR: state_d = func[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH;
         S_EXECR,
         S_EXECI:  state_d = S_ALUWB;
         S_ALUWB,
         S_BRANCH: state_d = S_FETCH;
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_FETCH;
      endcase

      // States that hold a memory request open and may stall on mem_ready.
      waiting     = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
      // A ready in the last allowed cycle wins over the timeout.
      timeout_hit = (TIMEOUT > 0) && waiting && !mem_ready && (wait_cnt_q == CNT_LAST);
      if (timeout_hit) state_d = S_FAULT;

      if (!waiting || mem_ready || (state_d != state_q)) wait_cnt_d = '0;
      else                                               wait_cnt_d = wait_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Moore decode of state, gated by the ready handshake where needed.
   // Reset forces every output low in the same cycle it is asserted.
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_req    = 1'b0;
      mem_w      = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_w      = 1'b0;
      branch     = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 1'b0;
      result_src = 2'b00;
      imm_src    = 2'b00;
      reg_src    = 2'b00;
      instr_done = 1'b0;
      illegal    = 1'b0;
      fault      = 1'b0;
      state      = rst ? 4'd0 : state_q;

      if (!rst && state_q != S_FAULT) begin
         unique case (op)
            OP_DP:   begin imm_src = func[5] ? 2'b00 : 2'b11; reg_src = func[5] ? 2'b10 : 2'b00; end
            OP_MEM:  begin imm_src = 2'b01;                   reg_src = func[0] ? 2'b00 : 2'b10; end
            OP_BR:   begin imm_src = 2'b10;                   reg_src = 2'b11;                   end
            default: ;
         endcase
      end

      if (!rst) begin
         unique case (state_q)
            S_FETCH: begin
               mem_req    = 1'b1;
               alu_src_a  = 2'b01;
               alu_src_b  = 2'b10;
               result_src = 2'b10;
               ir_write   = mem_ready;
               pc_write   = mem_ready;
            end
            S_DECODE: begin
               alu_src_a  = 2'b01;
               alu_src_b  = 2'b10;
               result_src = 2'b10;
               instr_done = !cond_ok;
               illegal    = cond_ok && (op != OP_DP) && (op != OP_MEM) && (op != OP_BR);
            end
            S_MEMADR: alu_src_b = 2'b01;
            S_MEMRD: begin
               mem_req = 1'b1;
               adr_src = 1'b1;
            end
            S_MEMWB: begin
               result_src = 2'b01;
               reg_w      = 1'b1;
               instr_done = 1'b1;
            end
            S_MEMWR: begin
               mem_req    = 1'b1;
               mem_w      = 1'b1;
               adr_src    = 1'b1;
               instr_done = mem_ready;
            end
            S_EXECR: alu_op = 1'b1;
            S_EXECI: begin
               alu_src_b = 2'b01;
               alu_op    = 1'b1;
            end
            S_ALUWB: begin
               reg_w      = 1'b1;
               instr_done = 1'b1;
            end
            S_BRANCH: begin
               alu_src_b  = 2'b01;
               result_src = 2'b10;
               branch     = 1'b1;
               pc_write   = 1'b1;
               instr_done = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_main_fsm
//
// Self-checking bench. Each instruction is expanded, at instruction level, into
// the list of cycles it must take (with its memory wait lengths) and the
// control word expected in each cycle. The list is then played against the DUT
// and every cycle's full control word is compared.
// -----------------------------------------------------------------------------
module tb_multicycle_main_fsm;

   typedef struct packed {
      logic [3:0] state;
      logic       mem_req, mem_w, adr_src, ir_write, pc_write, reg_w, branch;
      logic [1:0] alu_src_a, alu_src_b;
      logic       alu_op;
      logic [1:0] result_src, imm_src, reg_src;
      logic       instr_done, illegal, fault;
   } out_t;

   typedef struct {
      logic       rst;
      logic [1:0] op;
      logic [5:0] func;
      logic       cond;
      logic       rdy;
      out_t       exp;
      string      tag;
   } cyc_t;

   logic       clk, rst, cond_ok, mem_ready;
   logic [1:0] op;
   logic [5:0] func;
   logic       mem_req, mem_w, adr_src, ir_write, pc_write, reg_w, branch, alu_op;
   logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, reg_src;
   logic       instr_done, illegal, fault;
   logic [3:0] state;

   multicycle_main_fsm dut (
      .clk(clk), .rst(rst), .op(op), .func(func), .cond_ok(cond_ok), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_w(mem_w), .adr_src(adr_src), .ir_write(ir_write),
      .pc_write(pc_write), .reg_w(reg_w), .branch(branch), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
      .reg_src(reg_src), .instr_done(instr_done), .illegal(illegal), .fault(fault),
      .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   cyc_t  plan[$];
   out_t  got[$];
   out_t  want[$];
   string tags[$];

   logic       cur_rst;
   logic [1:0] cur_op;
   logic [5:0] cur_func;
   logic       cur_cond;

   // Operand decode straight from the encoding table.
   function automatic logic [1:0] imm_of(logic [1:0] o, logic [5:0] f);
      if (o == 2'd0) return f[5] ? 2'b00 : 2'b11;
      if (o == 2'd1) return 2'b01;
      if (o == 2'd2) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [1:0] rsrc_of(logic [1:0] o, logic [5:0] f);
      if (o == 2'd0) return f[5] ? 2'b10 : 2'b00;
      if (o == 2'd1) return f[0] ? 2'b00 : 2'b10;
      if (o == 2'd2) return 2'b11;
      return 2'b00;
   endfunction

   function automatic out_t base(int st);
      out_t o;
      o         = '0;
      o.state   = 4'(st);
      o.imm_src = imm_of(cur_op, cur_func);
      o.reg_src = rsrc_of(cur_op, cur_func);
      return o;
   endfunction

   task automatic push(input out_t e, input logic rdy, input string tag);
      cyc_t c;
      c.rst = cur_rst; c.op = cur_op; c.func = cur_func; c.cond = cur_cond;
      c.rdy = rdy; c.exp = e; c.tag = tag;
      plan.push_back(c);
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push_reset(input int n);
      for (int i = 0; i < n; i++) begin
         cur_rst = 1'b1; cur_op = 2'($urandom); cur_func = 6'($urandom); cur_cond = rnd_bit();
         push('0, rnd_bit(), "reset");
      end
      cur_rst = 1'b0;
   endtask

   task automatic push_fetch_waits(input int n);
      out_t o;
      o = base(0);
      o.mem_req = 1'b1; o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.result_src = 2'b10;
      for (int i = 0; i < n; i++) push(o, 1'b0, "fetch_wait");
   endtask

   task automatic push_fault(input int n);
      out_t o;
      o = '0; o.state = 4'd15; o.fault = 1'b1;
      for (int i = 0; i < n; i++) push(o, rnd_bit(), "fault");
   endtask

   // Expand one instruction into its expected cycles. fw / mw are the number of
   // not-ready cycles seen in FETCH and in the data memory access.
   task automatic push_instr(input logic [1:0] o_op, input logic [5:0] o_func,
                             input logic o_cond, input int fw, input int mw);
      out_t o;
      cur_op = o_op; cur_func = o_func; cur_cond = o_cond;
      push_fetch_waits(fw);
      o = base(0);
      o.mem_req = 1'b1; o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.result_src = 2'b10;
      o.ir_write = 1'b1; o.pc_write = 1'b1;
      push(o, 1'b1, "fetch");
      o = base(1);
      o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.result_src = 2'b10;
      if (!o_cond) begin
         o.instr_done = 1'b1;
         push(o, rnd_bit(), "decode_null");
         return;
      end
      if (o_op == 2'd3) begin
         o.illegal = 1'b1;
         push(o, rnd_bit(), "decode_illegal");
         return;
      end
      push(o, rnd_bit(), "decode");
      case (o_op)
         2'd1: begin
            o = base(2); o.alu_src_b = 2'b01;
            push(o, rnd_bit(), "memadr");
            if (o_func[0]) begin
               o = base(3); o.mem_req = 1'b1; o.adr_src = 1'b1;
               for (int i = 0; i < mw; i++) push(o, 1'b0, "memrd_wait");
               push(o, 1'b1, "memrd");
               o = base(4); o.result_src = 2'b01; o.reg_w = 1'b1; o.instr_done = 1'b1;
               push(o, rnd_bit(), "memwb");
            end else begin
               o = base(5); o.mem_req = 1'b1; o.mem_w = 1'b1; o.adr_src = 1'b1;
               for (int i = 0; i < mw; i++) push(o, 1'b0, "memwr_wait");
               o.instr_done = 1'b1;
               push(o, 1'b1, "memwr");
            end
         end
         2'd0: begin
            o = base(o_func[5] ? 7 : 6);
            o.alu_src_b = o_func[5] ? 2'b01 : 2'b00; o.alu_op = 1'b1;
            push(o, rnd_bit(), "exec");
            o = base(8); o.reg_w = 1'b1; o.instr_done = 1'b1;
            push(o, rnd_bit(), "aluwb");
         end
         default: begin
            o = base(9);
            o.alu_src_b = 2'b01; o.result_src = 2'b10; o.branch = 1'b1;
            o.pc_write = 1'b1; o.instr_done = 1'b1;
            push(o, rnd_bit(), "branch");
         end
      endcase
   endtask

   // Play the planned cycles: inputs driven after the falling edge, outputs
   // sampled 1 time unit later, well away from the rising edge.
   task automatic run();
      cyc_t c;
      got.delete(); want.delete(); tags.delete();
      while (plan.size() > 0) begin
         c = plan.pop_front();
         @(negedge clk);
         rst = c.rst; op = c.op; func = c.func; cond_ok = c.cond; mem_ready = c.rdy;
         #1;
         got.push_back({state, mem_req, mem_w, adr_src, ir_write, pc_write, reg_w, branch,
                        alu_src_a, alu_src_b, alu_op, result_src, imm_src, reg_src,
                        instr_done, illegal, fault});
         want.push_back(c.exp);
         tags.push_back(c.tag);
      end
   endtask

   task automatic test_reset();
      push_reset(3);
      run();
      for (int i = 0; i < got.size(); i++) begin
         n_total++;
         if (got[i] !== want[i])
            $display("FAIL reset[%0d] %s: got %h required %h", i, tags[i], got[i], want[i]);
         else n_pass++;
      end
   endtask

   task automatic test_directed();
      push_instr(2'd0, 6'b000000, 1'b1, 0, 0);   // DP register
      push_instr(2'd0, 6'b100000, 1'b1, 0, 0);   // DP immediate
      push_instr(2'd1, 6'b000001, 1'b1, 0, 3);   // LDR, 3 wait cycles
      push_instr(2'd1, 6'b000000, 1'b1, 1, 2);   // STR
      push_instr(2'd2, 6'b010101, 1'b1, 0, 0);   // branch
      push_instr(2'd1, 6'b000001, 1'b0, 0, 0);   // nullified
      push_instr(2'd3, 6'b111111, 1'b1, 0, 0);   // illegal
      run();
      for (int i = 0; i < got.size(); i++) begin
         n_total++;
         if (got[i] !== want[i])
            $display("FAIL directed[%0d] %s: got %h required %h", i, tags[i], got[i], want[i]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         int fw, mw;
         fw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 14)) : int'($urandom_range(0, 3));
         mw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 14)) : int'($urandom_range(0, 4));
         push_instr(2'($urandom), 6'($urandom), ($urandom_range(0, 3) != 0), fw, mw);
      end
      run();
      for (int i = 0; i < got.size(); i++) begin
         n_total++;
         if (got[i] !== want[i])
            $display("FAIL random[%0d] %s: got %h required %h", i, tags[i], got[i], want[i]);
         else n_pass++;
      end
   endtask

   // 15 not-ready FETCH cycles trip the fault; it holds until reset, after
   // which a ready on the 15th wait cycle (fetch and load) must not fault.
   task automatic test_timeout();
      cur_op = 2'd0; cur_func = 6'd0; cur_cond = 1'b1;
      push_fetch_waits(15);
      push_fault(5);
      push_reset(2);
      push_instr(2'd0, 6'b000000, 1'b1, 14, 0);
      push_instr(2'd1, 6'b000001, 1'b1, 0, 14);
      push_instr(2'd1, 6'b000000, 1'b1, 0, 14);
      run();
      for (int i = 0; i < got.size(); i++) begin
         n_total++;
         if (got[i] !== want[i])
            $display("FAIL timeout[%0d] %s: got %h required %h", i, tags[i], got[i], want[i]);
         else n_pass++;
      end
   endtask

   // Reset in the middle of a store wait aborts it; the next cycle is FETCH.
   task automatic test_rst_in_wait();
      push_instr(2'd1, 6'b000000, 1'b1, 0, 3);
      void'(plan.pop_back());                    // drop the completing cycle
      push_reset(1);
      push_instr(2'd0, 6'b100000, 1'b1, 0, 0);
      run();
      for (int i = 0; i < got.size(); i++) begin
         n_total++;
         if (got[i] !== want[i])
            $display("FAIL rst_in_wait[%0d] %s: got %h required %h", i, tags[i], got[i], want[i]);
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1; op = '0; func = '0; cond_ok = 1'b0; mem_ready = 1'b0;
      cur_rst = 1'b0; cur_op = '0; cur_func = '0; cur_cond = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_timeout();
      test_rst_in_wait();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
